// File: rtl/fft_frame_sequencer_if.sv
// Signal bundle around fft_frame_sequencer: sample stream in, fft_controller handoff,
// and result-bin stream out. The master side is the sequencer itself.
interface fft_frame_sequencer_if #(
    parameter int FFT_POINTS = 1024,
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = 40
);
    localparam int IDX_W = $clog2(FFT_POINTS);

    logic                         s_valid;
    logic                         s_ready;
    logic signed [DATA_WIDTH-1:0] s_data;
    logic                         s_fwd_inv;

    logic                         start_fft;
    logic                         forward_inverse;
    logic signed [DATA_WIDTH-1:0] in_data_real [FFT_POINTS];
    logic signed [DATA_WIDTH-1:0] in_data_imag [FFT_POINTS];
    logic signed [OUT_WIDTH-1:0]  out_data_real [FFT_POINTS];
    logic signed [OUT_WIDTH-1:0]  out_data_imag [FFT_POINTS];
    logic                         fft_data_valid;
    logic                         fft_in_prog;

    logic                         m_valid;
    logic                         m_ready;
    logic signed [OUT_WIDTH-1:0]  m_real;
    logic signed [OUT_WIDTH-1:0]  m_imag;
    logic [IDX_W-1:0]             m_index;
    logic                         m_last;
    logic [15:0]                  frame_count;

    modport master (
        input  s_valid, s_data, s_fwd_inv,
        input  out_data_real, out_data_imag, fft_data_valid, fft_in_prog,
        input  m_ready,
        output s_ready,
        output start_fft, forward_inverse, in_data_real, in_data_imag,
        output m_valid, m_real, m_imag, m_index, m_last, frame_count
    );

    modport slave (
        output s_valid, s_data, s_fwd_inv,
        output out_data_real, out_data_imag, fft_data_valid, fft_in_prog,
        output m_ready,
        input  s_ready,
        input  start_fft, forward_inverse, in_data_real, in_data_imag,
        input  m_valid, m_real, m_imag, m_index, m_last, frame_count
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Streaming front/back end for fft_controller: gathers one frame of real samples, launches
// the transform, then replays the controller's result bins as a valid/ready stream.
module fft_frame_sequencer #(
    parameter int FFT_POINTS = 1024,
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_frame_sequencer_if.master bus
);
    localparam int               IDX_W    = $clog2(FFT_POINTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 1);

    typedef enum logic [1:0] {
        FILL,
        START,
        WAIT,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             valid_q;

    logic             s_accept;
    logic             last_accept;
    logic             launch;
    logic             valid_rise;
    logic             m_handshake;
    logic             last_beat;

    // A launch can happen on the final accept itself when the controller is idle, which
    // puts start_fft on the very next cycle; otherwise START holds until it goes idle.
    // A rising edge coinciding with the start pulse predates the controller seeing it.
    always_comb begin
        s_accept    = (state == FILL) && bus.s_valid;
        last_accept = s_accept && (wr_idx == LAST_IDX);
        launch      = !bus.fft_in_prog && (last_accept || (state == START));
        valid_rise  = (state == WAIT) && !bus.start_fft && bus.fft_data_valid && !valid_q;
        m_handshake = (state == DRAIN) && bus.m_ready;
        last_beat   = m_handshake && (rd_idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (last_accept) begin
                    state_next = launch ? WAIT : START;
                end
            end
            START: begin
                if (launch) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (valid_rise) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_beat) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx              <= '0;
            rd_idx              <= '0;
            valid_q             <= 1'b0;
            bus.start_fft       <= 1'b0;
            bus.forward_inverse <= 1'b1;
            bus.frame_count     <= 16'd0;
            for (int i = 0; i < FFT_POINTS; i++) begin
                bus.in_data_real[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            valid_q       <= bus.fft_data_valid;
            bus.start_fft <= launch;
            if (s_accept) begin
                bus.in_data_real[wr_idx] <= bus.s_data;
                wr_idx                   <= wr_idx + 1'b1;
                if (wr_idx == '0) begin
                    bus.forward_inverse <= bus.s_fwd_inv;
                end
            end
            if (m_handshake) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (last_beat) begin
                bus.frame_count <= bus.frame_count + 16'd1;
            end
        end
    end

    // The controller holds its results until the next start, so bins are read straight
    // from its arrays; rd_idx only moves on a handshake, which keeps stalled beats stable.
    always_comb begin
        bus.s_ready = (state == FILL);
        bus.m_valid = (state == DRAIN);
        bus.m_real  = {OUT_WIDTH{1'b0}};
        bus.m_imag  = {OUT_WIDTH{1'b0}};
        bus.m_index = '0;
        bus.m_last  = 1'b0;
        if (state == DRAIN) begin
            bus.m_real  = bus.out_data_real[rd_idx];
            bus.m_imag  = bus.out_data_imag[rd_idx];
            bus.m_index = rd_idx;
            bus.m_last  = (rd_idx == LAST_IDX);
        end
    end

    always_comb begin
        for (int i = 0; i < FFT_POINTS; i++) begin
            bus.in_data_imag[i] = {DATA_WIDTH{1'b0}};
        end
    end
endmodule
